dkong_input_cond: RTL
=====================

Name: dkong_input_cond

Overview:
- Input conditioning stage between the HPS joystick word and the dkong_top player/coin inputs.
- Functions:
  - Debounces each control bit.
  - Resolves opposing directions (SOCD).
  - Stretches the coin press into a fixed-width, rate-limited coin pulse.
  - Gates all controls while the system is paused.
- Outputs are active-low and connect directly to dkong_top I_U1..I_C1.

Parameters:
- DEB_CYCLES, 24576: consecutive cycles a raw bit must differ from its stable value before it is accepted (1 ms at 24.576 MHz).
- COIN_CYCLES, 2457600: length of the asserted coin pulse, and separately of the mandatory gap after it (100 ms each).

Ports:
- I_CLK_24576M  in  1  system clock (clk_sys domain).
- I_RESETn  in  1  synchronous, active-low reset.
- I_JOY  in  16  raw joystick, active-high: [0] right, [1] left, [2] down, [3] up, [4] jump, [5] start1, [6] start2, [7] coin. Bits [15:8] are ignored.
- I_PAUSE  in  1  pause (user toggle | hiscore access), active-high.
- O_U_n, O_D_n, O_L_n, O_R_n  out  1 each  conditioned directions, active-low.
- O_J_n  out  1  jump, active-low.
- O_S1_n, O_S2_n  out  1 each  start buttons, active-low.
- O_C1_n  out  1  coin pulse, active-low.
- O_COIN_BUSY  out  1  high while the coin FSM is not IDLE.

Behaviour:
- Reset (I_RESETn=0 at a clock edge):
  - All *_n outputs = 1; O_COIN_BUSY = 0.
  - Stable bits = 0; debounce counters = 0; coin FSM = IDLE; coin_pending = 0; coin edge register = 0.
  - Reset mid-pulse aborts the pulse at the next edge.
- Debounce, per bit 0..7, independent:
  - If raw == stable: counter clears to 0.
  - Else: counter increments. When the counter reaches DEB_CYCLES-1, stable <= raw and counter <= 0 on the same edge.
  - A raw change held exactly DEB_CYCLES cycles is accepted. Any shorter glitch is rejected and the counter restarts.
  - Counter width is clog2(DEB_CYCLES)+1 and must not wrap.
  - The debouncers run during pause.
- SOCD, registered, 1-cycle latency after stable:
  - stable up & down both set → both outputs inactive.
  - stable left & right both set → both outputs inactive.
  - Output = ~resolved bit.
- Jump and starts: registered pass-through of the stable level, inverted, 1-cycle latency.
- Coin FSM (states IDLE, PULSE, GAP; 32-bit down-counter cnt):
  - A rising edge of stable coin is detected with a registered copy.
  - IDLE, edge or coin_pending → PULSE, cnt <= COIN_CYCLES-1, coin_pending cleared. O_C1_n = 0 from the next cycle.
  - PULSE: O_C1_n = 0. When cnt = 0 → GAP, cnt <= COIN_CYCLES-1; otherwise cnt decrements.
  - GAP: O_C1_n = 1. When cnt = 0 → IDLE; otherwise cnt decrements.
  - An edge during PULSE or GAP sets coin_pending. Only one press is queued; further edges are dropped.
  - An edge and a pending flag arriving together in IDLE count as one coin.
  - O_COIN_BUSY = (state != IDLE), registered.
- Pause (I_PAUSE=1):
  - All direction, jump, start and coin outputs are forced to 1 on the next edge.
  - Coin FSM state and cnt are frozen.
  - Coin edges during pause are discarded and do not set pending. The edge register still tracks the stable value, so no false edge appears at unpause.
  - On unpause, a PULSE resumes with its remaining count and O_C1_n returns to 0.
- Width/arithmetic: all counters are unsigned. Comparisons are against parameter-1, with no off-by-one slack. COIN_CYCLES ≥ 1 and DEB_CYCLES ≥ 1 are required.

Test Plan (use DEB_CYCLES=4, COIN_CYCLES=10):
- Debounce: raw up high for 3 cycles then low → O_U_n stays 1. Raw up held → O_U_n = 0 exactly 5 edges after raw rise (4 debounce + 1 output register).
- SOCD: stable up and down both set → O_U_n = O_D_n = 1. Release down → O_U_n = 0 after DEB_CYCLES+1 cycles.
- Coin:
  - One press → O_C1_n low for exactly 10 cycles, then high for 10, O_COIN_BUSY high for 20.
  - Second press during GAP → new 10-cycle pulse starts the cycle after GAP ends.
  - Third press during that same GAP → dropped.
- Pause mid-pulse: assert I_PAUSE at pulse cycle 4 for 7 cycles → O_C1_n = 1 during pause, then low for the remaining 6 cycles. Coin press during pause → no pulse.
- Reset mid-pulse: I_RESETn=0 at pulse cycle 5 → next edge all outputs 1, O_COIN_BUSY = 0. After release with raw coin still held high → exactly one new pulse once debounced.
- Start/jump: raw start1 and jump held → O_S1_n = O_J_n = 0 after 5 cycles. Assert I_PAUSE → both 1 next edge. Deassert I_PAUSE → both 0 next edge.

Source files
------------

// File: rtl/dkong_input_cond_if.sv
// Joystick/pause bundle into the input conditioner and the conditioned,
// active-low player/coin lines it returns to dkong_top.
interface dkong_input_cond_if;
    logic [15:0] I_JOY;
    logic        I_PAUSE;
    logic        O_U_n;
    logic        O_D_n;
    logic        O_L_n;
    logic        O_R_n;
    logic        O_J_n;
    logic        O_S1_n;
    logic        O_S2_n;
    logic        O_C1_n;
    logic        O_COIN_BUSY;

    // Source of the raw joystick word; consumer of the conditioned lines.
    modport master (
        output I_JOY, I_PAUSE,
        input  O_U_n, O_D_n, O_L_n, O_R_n, O_J_n, O_S1_n, O_S2_n, O_C1_n, O_COIN_BUSY
    );

    // The conditioner itself.
    modport slave (
        input  I_JOY, I_PAUSE,
        output O_U_n, O_D_n, O_L_n, O_R_n, O_J_n, O_S1_n, O_S2_n, O_C1_n, O_COIN_BUSY
    );
endinterface

// File: rtl/dkong_input_cond.sv
// Input conditioning between the HPS joystick word and dkong_top:
// per-bit debounce, SOCD resolution, coin pulse stretching with a
// mandatory gap and one queued press, and control gating while paused.
module dkong_input_cond #(
    parameter int DEB_CYCLES  = 24576,
    parameter int COIN_CYCLES = 2457600
) (
    input logic              I_CLK_24576M,
    input logic              I_RESETn,
    dkong_input_cond_if.slave bus
);

    localparam int              DCW       = $clog2(DEB_CYCLES) + 1;
    localparam logic [DCW-1:0]  DEB_LAST  = DCW'(DEB_CYCLES - 1);
    localparam logic [31:0]     COIN_LAST = 32'(COIN_CYCLES - 1);

    // Raw bit positions inside the joystick word.
    localparam int B_R  = 0;
    localparam int B_L  = 1;
    localparam int B_D  = 2;
    localparam int B_U  = 3;
    localparam int B_J  = 4;
    localparam int B_S1 = 5;
    localparam int B_S2 = 6;
    localparam int B_C  = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } coin_state_e;

    logic [7:0] raw;
    logic       pause;
    logic       unused_joy_hi;

    assign raw           = bus.I_JOY[7:0];
    assign pause         = bus.I_PAUSE;
    assign unused_joy_hi = ^bus.I_JOY[15:8];

    // Debounce state
    logic [7:0]     stable_q, stable_d;
    logic [DCW-1:0] deb_cnt_q [8];
    logic [DCW-1:0] deb_cnt_d [8];

    // Coin FSM state
    coin_state_e state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        pending_q, pending_d;
    logic        coin_prev_q, coin_prev_d;
    logic        coin_edge;

    // Registered outputs
    logic u_n_q, u_n_d, d_n_q, d_n_d, l_n_q, l_n_d, r_n_q, r_n_d;
    logic j_n_q, j_n_d, s1_n_q, s1_n_d, s2_n_q, s2_n_d;
    logic c1_n_q, c1_n_d, busy_q, busy_d;

    // Per-bit debounce: accept a new level only after DEB_CYCLES consecutive differing samples.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        stable_d = stable_q;
        for (int i = 0; i < 8; i++) begin
            deb_cnt_d[i] = '0;
            if (raw[i] != stable_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    stable_d[i] = raw[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DCW'(1);
                end
            end
        end
    end

    // Rising edge of the debounced coin; the edge register follows stable coin even while paused.
    always_comb begin
        coin_prev_d = stable_q[B_C];
        coin_edge   = stable_q[B_C] & ~coin_prev_q;
    end

    // Coin FSM next state: frozen while paused, edges during pause are discarded.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        if (!pause) begin
            unique case (state_q)
                IDLE: begin
                    if (coin_edge || pending_q) begin
                        state_d   = PULSE;
                        cnt_d     = COIN_LAST;
                        pending_d = 1'b0;
                    end
                end
                PULSE: begin
                    if (coin_edge) pending_d = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = GAP;
                        cnt_d   = COIN_LAST;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                GAP: begin
                    if (coin_edge) pending_d = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output values for the next edge: SOCD-resolved directions, pass-through buttons, coin pulse.
    always_comb begin
        u_n_d  = pause | ~(stable_q[B_U] & ~stable_q[B_D]);
        d_n_d  = pause | ~(stable_q[B_D] & ~stable_q[B_U]);
        l_n_d  = pause | ~(stable_q[B_L] & ~stable_q[B_R]);
        r_n_d  = pause | ~(stable_q[B_R] & ~stable_q[B_L]);
        j_n_d  = pause | ~stable_q[B_J];
        s1_n_d = pause | ~stable_q[B_S1];
        s2_n_d = pause | ~stable_q[B_S2];
        c1_n_d = pause | (state_d != PULSE);
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge I_CLK_24576M) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!I_RESETn) begin
            stable_q    <= '0;
            for (int i = 0; i < 8; i++) deb_cnt_q[i] <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            coin_prev_q <= 1'b0;
            u_n_q       <= 1'b1;
            d_n_q       <= 1'b1;
            l_n_q       <= 1'b1;
            r_n_q       <= 1'b1;
            j_n_q       <= 1'b1;
            s1_n_q      <= 1'b1;
            s2_n_q      <= 1'b1;
            c1_n_q      <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            stable_q    <= stable_d;
            for (int i = 0; i < 8; i++) deb_cnt_q[i] <= deb_cnt_d[i];
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            coin_prev_q <= coin_prev_d;
            u_n_q       <= u_n_d;
            d_n_q       <= d_n_d;
            l_n_q       <= l_n_d;
            r_n_q       <= r_n_d;
            j_n_q       <= j_n_d;
            s1_n_q      <= s1_n_d;
            s2_n_q      <= s2_n_d;
            c1_n_q      <= c1_n_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.O_U_n       = u_n_q;
    assign bus.O_D_n       = d_n_q;
    assign bus.O_L_n       = l_n_q;
    assign bus.O_R_n       = r_n_q;
    assign bus.O_J_n       = j_n_q;
    assign bus.O_S1_n      = s1_n_q;
    assign bus.O_S2_n      = s2_n_q;
    assign bus.O_C1_n      = c1_n_q;
    assign bus.O_COIN_BUSY = busy_q;

endmodule
